div_iter_unit: RTL and testbench

- Multi-cycle iterative 32-bit divider; responder side of the EX-stage divide handshake (start/ready/annul).
- EX drives operands, signedness and start, and holds its stall request until ready_o.
- The block returns {remainder, quotient}: remainder goes to HI, quotient to LO.
- Restoring radix-2 algorithm, one quotient bit per cycle.

---
 rtl/div_iter_unit_if.sv | 36 +++
 rtl/div_iter_unit.sv | 192 +++++++++++++++++++
 tb/tb_div_iter_unit.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_unit_if
// Purpose  : Divide handshake bundle between the EX stage (master) and the
//            iterative divider (slave).
// Signals  : signed_div_i - 1 = signed divide, 0 = unsigned
//            opdata1_i    - dividend
//            opdata2_i    - divisor
//            start_i      - request, held by EX until ready_o is seen
//            annul_i      - abort the in-flight divide
//            result_o     - {remainder, quotient}
//            ready_o      - result valid
// Revision : 1.0 - initial release
// ============================================================================
interface div_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface
`default_nettype wire

// File: rtl/div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_unit
// Purpose  : Multi-cycle restoring radix-2 divider, one quotient bit per
//            cycle. Returns {remainder, quotient} (remainder -> HI,
//            quotient -> LO). Signed divides run on magnitudes and get a
//            sign fixup on the last iteration.
// Ports    : clk - clock, rising edge
//            rst - synchronous active-high reset
//            bus - div_iter_unit_if.slave handshake (operands, start,
//                  annul, result, ready)
// Options  : DIV_EARLY_OUT_EN - when defined, a divide whose |dividend| is
//            below |divisor| completes straight from IDLE with quotient 0
//            and remainder equal to the original dividend. Results are the
//            same either way; only latency changes.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  wire logic       clk,
  input  wire logic       rst,
  div_iter_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem;        // partial remainder
  logic [WIDTH-1:0]   dvd;        // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dsr;        // divisor magnitude
  logic               sgn_mode;
  logic               neg_a;
  logic               neg_b;
  logic [2*WIDTH-1:0] result;

  // ---------------------------------------------------------------------
  // Operand conditioning (only meaningful in IDLE, when operands latch)
  // ---------------------------------------------------------------------
  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             div_zero;
  logic             early;
  logic             accept;

  // INT_MIN negates to itself, which read as unsigned is the right magnitude.
  assign a_neg_in = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign b_neg_in = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign abs_a    = a_neg_in ? (-bus.opdata1_i) : bus.opdata1_i;
  assign abs_b    = b_neg_in ? (-bus.opdata2_i) : bus.opdata2_i;
  assign div_zero = (bus.opdata2_i == '0);
  assign accept   = bus.start_i & ~bus.annul_i;

`ifdef DIV_EARLY_OUT_EN
  assign early = (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // One restoring step: shift {rem, dvd} left, trial-subtract the divisor
  // with one extra bit so the top bit of the difference is the borrow.
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   shift_rem;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign shift_rem = {rem, dvd[WIDTH-1]};
  assign diff      = shift_rem - {1'b0, dsr};
  assign no_borrow = ~diff[WIDTH];
  assign rem_next  = no_borrow ? diff[WIDTH-1:0] : shift_rem[WIDTH-1:0];
  assign q_next    = {dvd[WIDTH-2:0], no_borrow};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Quotient sign follows the XOR of operand signs; remainder takes the
  // dividend's sign. Both flags are zero in unsigned mode by construction.
  assign q_fix = (sgn_mode & (neg_a ^ neg_b)) ? (-q_next)   : q_next;
  assign r_fix = (sgn_mode & neg_a)           ? (-rem_next) : rem_next;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (div_zero) begin
            state_nxt = BY_ZERO;
          end else if (early) begin
            state_nxt = END;
          end else begin
            state_nxt = ON;
          end
        end
      end
      BY_ZERO: state_nxt = END;
      ON: begin
        // start_i dropping here is ignored; only annul or reset abort.
        if (bus.annul_i) begin
          state_nxt = IDLE;
        end else if (last_iter) begin
          state_nxt = END;
        end
      end
      END: begin
        if (!bus.start_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      sgn_mode <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !div_zero) begin
            if (early) begin
              result <= {bus.opdata1_i, {WIDTH{1'b0}}};
            end else begin
              dvd      <= abs_a;
              dsr      <= abs_b;
              rem      <= '0;
              cnt      <= '0;
              sgn_mode <= bus.signed_div_i;
              neg_a    <= a_neg_in;
              neg_b    <= b_neg_in;
            end
          end
        end
        BY_ZERO: begin
          result <= '0;
        end
        ON: begin
          if (!bus.annul_i) begin
            rem <= rem_next;
            dvd <= q_next;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
              result <= {r_fix, q_fix};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready_o  = (state == END);
  assign bus.result_o = result;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter_unit
// Purpose  : Self-checking bench for div_iter_unit. Directed scenarios plus
//            randomized divides compared against a plain-arithmetic model.
//            Follows DIV_EARLY_OUT_EN for expected latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter_unit;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  div_iter_unit_if #(.WIDTH(32)) bus ();

  div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, time=%0t required=<1000000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input bit s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Clock edges from the edge where start is driven until ready_o is seen.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (s && a[31]) ? (32'd0 - a) : a;
    mb = (s && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    if (ma == mb) return 33;
    return 33;
  endfunction

  // ---------------------------------------------------------------------
  // Stimulus helper: one complete transaction with start held until ready
  // ---------------------------------------------------------------------
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                       output logic [63:0] res, output int lat, output logic rdy_after);
    @(posedge clk); #1;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.start_i      = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      // Operands must already be latched; scrambling them must not matter.
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = 1'($urandom);
      if (bus.ready_o) break;
    end
    res = bus.result_o;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rdy_after = bus.ready_o;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b1;
    bus.annul_i = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd10;
    bus.opdata2_i = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 0", bus.ready_o);
    end
    tests_run++;
    if (bus.result_o !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h want 0", bus.result_o);
    end
    bus.start_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_unsigned_basic();
    logic [63:0] res;
    int lat;
    logic ra;
    do_op(32'd100, 32'd7, 1'b0, res, lat, ra);
    tests_run++;
    if (res !== {32'd2, 32'd14}) begin
      tests_failed++;
      $display("FAIL u100_7_result: got %h want %h", res, {32'd2, 32'd14});
    end
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL u100_7_latency: got %0d want 33", lat);
    end
    tests_run++;
    if (ra !== 1'b0) begin
      tests_failed++;
      $display("FAIL u100_7_ready_drop: got %b want 0", ra);
    end
  endtask

  task automatic test_signed();
    logic [63:0] res;
    int lat;
    logic ra;
    do_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, res, lat, ra);
    tests_run++;
    if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      tests_failed++;
      $display("FAIL s_m7_2: got %h want %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    do_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, res, lat, ra);
    tests_run++;
    if (res !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
      tests_failed++;
      $display("FAIL s_7_m2: got %h want %h", res, {32'h0000_0001, 32'hFFFF_FFFD});
    end
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL s_7_m2_latency: got %0d want 33", lat);
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] res;
    int lat;
    logic ra;
    do_op(32'd5, 32'd0, 1'b0, res, lat, ra);
    tests_run++;
    if (res !== 64'd0) begin
      tests_failed++;
      $display("FAIL div0_result: got %h want 0", res);
    end
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("FAIL div0_latency: got %0d want 2", lat);
    end
    tests_run++;
    if (ra !== 1'b0) begin
      tests_failed++;
      $display("FAIL div0_ready_drop: got %b want 0", ra);
    end
  endtask

  task automatic test_corners();
    logic [63:0] res;
    int lat;
    logic ra;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, ra);
    tests_run++;
    if (res !== {32'd0, 32'h8000_0000}) begin
      tests_failed++;
      $display("FAIL intmin_m1: got %h want %h", res, {32'd0, 32'h8000_0000});
    end
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, res, lat, ra);
    tests_run++;
    if (res !== {32'd0, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL umax_1: got %h want %h", res, {32'd0, 32'hFFFF_FFFF});
    end
  endtask

  task automatic test_annul();
    logic [63:0] prev;
    logic [63:0] res;
    int lat;
    logic ra;
    bit seen;
    prev = bus.result_o;
    @(posedge clk); #1;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.signed_div_i = 1'b0;
    bus.start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready_o) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL annul_no_ready: got %b want 0", seen);
    end
    tests_run++;
    if (bus.result_o !== prev) begin
      tests_failed++;
      $display("FAIL annul_result_held: got %h want %h", bus.result_o, prev);
    end
    do_op(32'd9, 32'd3, 1'b0, res, lat, ra);
    tests_run++;
    if (res !== {32'd0, 32'd3}) begin
      tests_failed++;
      $display("FAIL after_annul_result: got %h want %h", res, {32'd0, 32'd3});
    end
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL after_annul_latency: got %0d want 33", lat);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.signed_div_i = 1'b0;
    bus.start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus.ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_ready: got %b want 0", bus.ready_o);
    end
    tests_run++;
    if (bus.result_o !== 64'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_result: got %h want 0", bus.result_o);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready_o) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_ready: got %b want 0", seen);
    end
  endtask

  task automatic test_hold_start();
    int lat;
    @(posedge clk); #1;
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.signed_div_i = 1'b0;
    bus.start_i = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.ready_o) break;
    end
    tests_run++;
    if (bus.result_o !== {32'd0, 32'd10}) begin
      tests_failed++;
      $display("FAIL hold_result: got %h want %h", bus.result_o, {32'd0, 32'd10});
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== {32'd0, 32'd10}) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: got ready=%b result=%h want ready=1 result=%h",
                 i, bus.ready_o, bus.result_o, {32'd0, 32'd10});
      end
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== {32'd0, 32'd10}) begin
      tests_failed++;
      $display("FAIL hold_release: got ready=%b result=%h want ready=0 result=%h",
               bus.ready_o, bus.result_o, {32'd0, 32'd10});
    end
  endtask

  task automatic test_small_dividend();
    logic [63:0] res;
    int lat;
    logic ra;
    do_op(32'd3, 32'd10, 1'b0, res, lat, ra);
    tests_run++;
    if (res !== {32'd3, 32'd0}) begin
      tests_failed++;
      $display("FAIL small_3_10_result: got %h want %h", res, {32'd3, 32'd0});
    end
    tests_run++;
    if (lat !== ref_lat(32'd3, 32'd10, 1'b0)) begin
      tests_failed++;
      $display("FAIL small_3_10_latency: got %0d want %0d", lat, ref_lat(32'd3, 32'd10, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    bit s;
    logic [63:0] res;
    logic [63:0] exp;
    int lat;
    logic ra;
    for (int n = 0; n < 30; n++) begin
      s = 1'($urandom);
      case ($urandom_range(0, 5))
        0: a = $urandom_range(0, 20);
        1: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'd0 - 32'($urandom_range(1, 15));
        3: b = $urandom >> 16;
        default: b = $urandom;
      endcase
      exp = ref_div(a, b, s);
      do_op(a, b, s, res, lat, ra);
      tests_run++;
      if (res !== exp) begin
        tests_failed++;
        $display("FAIL rand%0d_result a=%h b=%h s=%0d: got %h want %h", n, a, b, s, res, exp);
      end
      tests_run++;
      if (lat !== ref_lat(a, b, s)) begin
        tests_failed++;
        $display("FAIL rand%0d_latency a=%h b=%h s=%0d: got %0d want %0d",
                 n, a, b, s, lat, ref_lat(a, b, s));
      end
      tests_run++;
      if (ra !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand%0d_ready_drop: got %b want 0", n, ra);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_corners();
    test_annul();
    test_reset_mid();
    test_hold_start();
    test_small_dividend();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
